// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: state register plus retired-instruction
// counter; all datapath strobes are decoded combinationally from the state.
module multicycle_ctrl #(
   parameter int RET_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       opcode_i,
   input  logic             mem_ready_i,
   input  logic             zero_i,
   output logic             pc_write_o,
   output logic             ir_write_o,
   output logic             iord_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             reg_write_o,
   output logic             reg_dst_o,
   output logic             mem_to_reg_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic [1:0]       pc_src_o,
   output logic [3:0]       state_o,
   output logic             halted_o,
   output logic [RET_W-1:0] retired_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD = 4'd3,
      MEM_WB   = 4'd4,  MEM_WR = 4'd5,  R_EXE    = 4'd6,  R_WB   = 4'd7,
      BRANCH   = 4'd8,  JUMP   = 4'd9,  I_EXE    = 4'd10, I_WB   = 4'd11,
      HALT     = 4'd12
   } state_t;

   state_t state, next;
   logic   retire;

   always_comb begin
      next   = state;
      retire = 1'b0;
      case (state)
         FETCH:    if (mem_ready_i) next = DECODE;
         DECODE: begin
            case (opcode_i)
               6'b000000:            next = R_EXE;
               6'b100011, 6'b101011: next = MEM_ADDR;
               6'b000100:            next = BRANCH;
               6'b000010:            next = JUMP;
               6'b001000:            next = I_EXE;
               default:              next = HALT;
            endcase
         end
         MEM_ADDR: next = (opcode_i == 6'b100011) ? MEM_RD : MEM_WR;
         MEM_RD:   if (mem_ready_i) next = MEM_WB;
         MEM_WR: begin
            if (mem_ready_i) begin
               next   = FETCH;
               retire = 1'b1;
            end
         end
         MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
            next   = FETCH;
            retire = 1'b1;
         end
         R_EXE:    next = R_WB;
         I_EXE:    next = I_WB;
         HALT:     next = HALT;
         default:  next = HALT;   // unused encodings 13-15 park in HALT
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= FETCH;
         retired_o <= '0;
      end else begin
         state <= next;
         if (retire) retired_o <= retired_o + RET_W'(1);
      end
   end

   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'd0;
      alu_op_o     = 2'b00;
      pc_src_o     = 2'b00;
      halted_o     = 1'b0;
      case (state)
         FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'd1;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         DECODE:   alu_src_b_o = 2'd3;   // speculative branch target
         MEM_ADDR, I_EXE: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd2;
         end
         MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
         end
         MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         MEM_WR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
         end
         R_EXE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 2'b10;
         end
         R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 1'b1;
         end
         I_WB:     reg_write_o = 1'b1;
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 2'b01;
            pc_src_o    = 2'b01;
            pc_write_o  = zero_i;
         end
         JUMP: begin
            pc_src_o   = 2'b10;
            pc_write_o = 1'b1;
         end
         HALT:     halted_o = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one task per scenario with inline checks.
// A second instance with RET_W=4 covers counter wrap.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       zero = 1'b0;

   logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
   logic        reg_dst, mem_to_reg, alu_src_a, halted;
   logic [1:0]  alu_src_b, alu_op, pc_src;
   logic [3:0]  state;
   logic [15:0] retired;

   logic        pc_write4, ir_write4, iord4, mem_read4, mem_write4, reg_write4;
   logic        reg_dst4, mem_to_reg4, alu_src_a4, halted4;
   logic [1:0]  alu_src_b4, alu_op4, pc_src4;
   logic [3:0]  state4;
   logic [3:0]  retired4;

   logic [15:0] ovec;
   assign ovec = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, halted};

   // Expected output vector per state, mem_ready=1 and zero=1.
   logic [15:0] otab [13] = '{16'hD020, 16'h0060, 16'h00C0, 16'h3000, 16'h0500,
                              16'h2800, 16'h0090, 16'h0600, 16'h808A, 16'h8004,
                              16'h00C0, 16'h0400, 16'h0001};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.RET_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready), .zero_i(zero),
      .pc_write_o(pc_write), .ir_write_o(ir_write), .iord_o(iord), .mem_read_o(mem_read),
      .mem_write_o(mem_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
      .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .alu_op_o(alu_op), .pc_src_o(pc_src), .state_o(state), .halted_o(halted),
      .retired_o(retired));

   multicycle_ctrl #(.RET_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready), .zero_i(zero),
      .pc_write_o(pc_write4), .ir_write_o(ir_write4), .iord_o(iord4), .mem_read_o(mem_read4),
      .mem_write_o(mem_write4), .reg_write_o(reg_write4), .reg_dst_o(reg_dst4),
      .mem_to_reg_o(mem_to_reg4), .alu_src_a_o(alu_src_a4), .alu_src_b_o(alu_src_b4),
      .alu_op_o(alu_op4), .pc_src_o(pc_src4), .state_o(state4), .halted_o(halted4),
      .retired_o(retired4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 4 time units after a rising edge with state FETCH.
   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      #3 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0;
      #2;
      total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
      total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
      total++; if (ovec !== 16'h1020) begin bad++; $display("FAIL reset_out_nr got=%h exp=1020", ovec); end
      mem_ready = 1'b1;
      #1;
      total++; if (ovec !== 16'hD020) begin bad++; $display("FAIL reset_out_rdy got=%h exp=d020", ovec); end
      tick();
      total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_held got=%0d exp=0", state); end
      #3 rst = 1'b1;
   endtask

   task automatic test_sequence();
      logic [5:0] ops  [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
      int         lens [6] = '{4, 5, 4, 3, 3, 4};
      logic [3:0] seq  [23] = '{4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0,
                                4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9,
                                4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
      int k = 0;
      mem_ready = 1'b1; zero = 1'b1;
      do_reset();
      total++; if (ovec !== 16'hD020) begin bad++; $display("FAIL seq_fetch_out got=%h exp=d020", ovec); end
      for (int i = 0; i < 6; i++) begin
         opcode = ops[i];
         for (int j = 0; j < lens[i]; j++) begin
            tick();
            total++;
            if (state !== seq[k]) begin
               bad++; $display("FAIL seq_state[%0d] got=%0d exp=%0d", k, state, seq[k]);
            end
            total++;
            if (ovec !== otab[seq[k]]) begin
               bad++; $display("FAIL seq_out[%0d] got=%h exp=%h", k, ovec, otab[seq[k]]);
            end
            k++;
         end
         if (i == 4) begin
            total++; if (retired !== 16'd5) begin bad++; $display("FAIL seq_retired5 got=%0d exp=5", retired); end
         end
      end
      total++; if (retired !== 16'd6) begin bad++; $display("FAIL seq_retired6 got=%0d exp=6", retired); end
      total++; if (retired4 !== 4'd6) begin bad++; $display("FAIL seq_retired4 got=%0d exp=6", retired4); end
   endtask

   task automatic test_fetch_stall();
      mem_ready = 1'b1; opcode = 6'h00;
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (state !== 4'd0) begin bad++; $display("FAIL fstall_state got=%0d exp=0", state); end
         total++; if (ovec !== 16'h1020) begin bad++; $display("FAIL fstall_out got=%h exp=1020", ovec); end
      end
      mem_ready = 1'b1;
      tick();
      total++; if (state !== 4'd1) begin bad++; $display("FAIL fstall_exit got=%0d exp=1", state); end
   endtask

   task automatic test_lw_stall();
      mem_ready = 1'b1; opcode = 6'h23; zero = 1'b0;
      do_reset();
      tick(); tick(); tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (state !== 4'd3) begin bad++; $display("FAIL lw_hold_state got=%0d exp=3", state); end
         total++; if (ovec !== 16'h3000) begin bad++; $display("FAIL lw_hold_out got=%h exp=3000", ovec); end
         tick();
      end
      mem_ready = 1'b1;
      #1;
      total++; if (state !== 4'd3) begin bad++; $display("FAIL lw_hold4 got=%0d exp=3", state); end
      total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL lw_rw_early got=%b exp=0", reg_write); end
      tick();
      total++; if (state !== 4'd4 || reg_write !== 1'b1) begin
         bad++; $display("FAIL lw_wb got=%0d/%b exp=4/1", state, reg_write);
      end
      tick();
      total++; if (state !== 4'd0 || retired !== 16'd1) begin
         bad++; $display("FAIL lw_done got=%0d/%0d exp=0/1", state, retired);
      end
   endtask

   task automatic test_sw_stall();
      mem_ready = 1'b1; opcode = 6'h2B;
      do_reset();
      tick(); tick(); tick();
      total++; if (state !== 4'd5) begin bad++; $display("FAIL sw_enter got=%0d exp=5", state); end
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (ovec !== 16'h2800) begin bad++; $display("FAIL sw_hold_out got=%h exp=2800", ovec); end
         tick();
      end
      total++; if (state !== 4'd5 || retired !== 16'd0) begin
         bad++; $display("FAIL sw_held got=%0d/%0d exp=5/0", state, retired);
      end
      mem_ready = 1'b1;
      tick();
      total++; if (state !== 4'd0 || retired !== 16'd1) begin
         bad++; $display("FAIL sw_done got=%0d/%0d exp=0/1", state, retired);
      end
   endtask

   task automatic test_branch();
      mem_ready = 1'b1; opcode = 6'h04; zero = 1'b0;
      do_reset();
      tick(); tick();
      total++; if (state !== 4'd8) begin bad++; $display("FAIL beq_state got=%0d exp=8", state); end
      total++; if (ovec !== 16'h008A) begin bad++; $display("FAIL beq_nz_out got=%h exp=008a", ovec); end
      zero = 1'b1;
      #1;
      total++; if (pc_write !== 1'b1 || pc_src !== 2'b01) begin
         bad++; $display("FAIL beq_z got=%b/%b exp=1/01", pc_write, pc_src);
      end
      tick();
      total++; if (state !== 4'd0 || retired !== 16'd1) begin
         bad++; $display("FAIL beq_done got=%0d/%0d exp=0/1", state, retired);
      end
   endtask

   task automatic test_halt();
      mem_ready = 1'b1; opcode = 6'h3F;
      do_reset();
      tick(); tick();
      for (int i = 0; i < 20; i++) begin
         zero = i[0]; mem_ready = i[1];
         #1;
         total++; if (state !== 4'd12) begin bad++; $display("FAIL halt_state got=%0d exp=12", state); end
         total++; if (ovec !== 16'h0001) begin bad++; $display("FAIL halt_out got=%h exp=0001", ovec); end
         total++; if (retired !== 16'd0) begin bad++; $display("FAIL halt_retired got=%0d exp=0", retired); end
         tick();
      end
      rst = 1'b0;
      #1;
      total++; if (state !== 4'd0 || halted !== 1'b0) begin
         bad++; $display("FAIL halt_reset got=%0d/%b exp=0/0", state, halted);
      end
      #1 rst = 1'b1;
   endtask

   task automatic test_reset_mid_write();
      mem_ready = 1'b1; opcode = 6'h2B;
      do_reset();
      tick(); tick(); tick();
      mem_ready = 1'b0;
      tick();
      total++; if (state !== 4'd5 || mem_write !== 1'b1) begin
         bad++; $display("FAIL mwr_pre got=%0d/%b exp=5/1", state, mem_write);
      end
      #2 rst = 1'b0;
      #1;
      total++; if (state !== 4'd0 || mem_write !== 1'b0) begin
         bad++; $display("FAIL mwr_abort got=%0d/%b exp=0/0", state, mem_write);
      end
      total++; if (retired !== 16'd0) begin bad++; $display("FAIL mwr_retired got=%0d exp=0", retired); end
      #1 rst = 1'b1;
      mem_ready = 1'b1;
      tick();
      total++; if (state !== 4'd1) begin bad++; $display("FAIL mwr_first got=%0d exp=1", state); end
   endtask

   task automatic test_wrap();
      mem_ready = 1'b1; opcode = 6'h02;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         tick(); tick(); tick();
         if (i == 14) begin
            total++; if (retired4 !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", retired4); end
         end
      end
      total++; if (retired4 !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", retired4); end
      total++; if (retired !== 16'd16) begin bad++; $display("FAIL wrap_wide got=%0d exp=16", retired); end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_fetch_stall();
      test_lw_stall();
      test_sw_stall();
      test_branch();
      test_halt();
      test_reset_mid_write();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: RET_W, 16, width of retired-instruction counter.
REQ-002 Port: clk_i  input  1  sole clock, rising-edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 Port: opcode_i  input  6  instr[31:26] from instruction register.
REQ-005 Port: mem_ready_i  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-006 Port: zero_i  input  1  ALU zero flag.
REQ-007 Port: pc_write_o  output  1  PC load enable.
REQ-008 Port: ir_write_o  output  1  instruction register load enable.
REQ-009 Port: iord_o  output  1  memory address select (0 = PC, 1 = ALUOut).
REQ-010 Port: mem_read_o / mem_write_o  output  1 each  memory strobes.
REQ-011 Port: reg_write_o  output  1  register file write enable.
REQ-012 Port: reg_dst_o / mem_to_reg_o  output  1 each  write-address select (1 = rd) and write-data select (1 = MDR).
REQ-013 Port: alu_src_a_o  output  1 (0 = PC, 1 = rs); alu_src_b_o  output  2 (0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2).
REQ-014 Port: alu_op_o  output  2  00 add, 01 sub, 10 use funct.
REQ-015 Port: pc_src_o  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-016 Port: state_o  output  4  current state encoding; halted_o  output  1; retired_o  output  RET_W.

Function
REQ-017 State register SHALL hold exactly: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BRANCH=8, JUMP=9, I_EXE=10, I_WB=11, HALT=12; codes 13-15 SHALL go to HALT next cycle.
REQ-018 FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=00, pc_src_o=00; ir_write_o and pc_write_o = mem_ready_i; state holds while mem_ready_i=0, goes to DECODE when 1.
REQ-019 DECODE: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=00; next state by opcode_i: 000000 to R_EXE, 100011 or 101011 to MEM_ADDR, 000100 to BRANCH, 000010 to JUMP, 001000 to I_EXE, any other to HALT.
REQ-020 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=00; to MEM_RD if opcode_i=100011, else MEM_WR.
REQ-021 MEM_RD: mem_read_o=1, iord_o=1; holds until mem_ready_i=1, then MEM_WB.
REQ-022 MEM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1; to FETCH.
REQ-023 MEM_WR: mem_write_o=1, iord_o=1; mem_write_o SHALL remain asserted every cycle until mem_ready_i=1, then FETCH.
REQ-024 R_EXE: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=10; to R_WB. R_WB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; to FETCH.
REQ-025 I_EXE: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=00; to I_WB. I_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0; to FETCH.
REQ-026 BRANCH: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=01, pc_src_o=01, pc_write_o=zero_i; to FETCH.
REQ-027 JUMP: pc_src_o=10, pc_write_o=1; to FETCH.
REQ-028 HALT: all strobes/enables 0, halted_o=1, state SHALL remain HALT until reset.
REQ-029 Any output not listed for a state SHALL be 0.
REQ-030 Strobes SHALL be combinational from state (plus mem_ready_i/zero_i where stated); no output registered beyond state and retired_o.
REQ-031 retired_o SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP; wraps 2^RET_W-1 to 0; never increments on HALT entry.
REQ-032 Minimum latencies (mem_ready_i=1): lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-033 rst_i=0 SHALL immediately, independent of clk_i, force state FETCH, retired_o=0, halted_o=0; all strobes then follow FETCH decode with mem_ready_i.
REQ-034 Reset asserted mid-instruction (any state, including an unfinished MEM_WR) SHALL abort it with no further reg_write_o/mem_write_o pulse; first post-reset edge evaluates FETCH.

Verification
REQ-035 Release reset, mem_ready_i=1, opcodes R, lw, sw, beq(zero_i=1), j -> state sequence 0,1,6,7,0,1,2,3,4,0,1,2,5,0,1,8,0,1,9,0; retired_o=5.
REQ-036 lw with mem_ready_i=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read_o=1 and iord_o=1 throughout, reg_write_o only in MEM_WB.
REQ-037 beq with zero_i=0 -> pc_write_o=0 in BRANCH; zero_i=1 -> pc_write_o=1, pc_src_o=01.
REQ-038 opcode_i=111111 in DECODE -> HALT, halted_o=1, all strobes 0 for 20 cycles, retired_o unchanged; rst_i low then high -> FETCH.
REQ-039 Assert rst_i=0 between clock edges during MEM_WR -> state_o=0 and mem_write_o=0 before next rising edge.
REQ-040 RET_W=4, 16 retired instructions from 0 -> retired_o=0 (wrap).
